// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-port data RAM between the CPU and loader ports.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is EXT-first fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = (MEM_LAT < 4) ? 2 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [CW-1:0] lat_cnt;
    logic          last_grant;
    logic          acc_we;
    logic          pick_ext;
    logic          win_we;

    // last_grant doubles as the current owner while an access is in flight
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign pick_ext = ext_req & (~cpu_req | ~last_grant);
`else
    assign pick_ext = ext_req;
`endif
    assign win_we    = pick_ext ? ext_we : cpu_we;
    assign cpu_stall = cpu_req & ~cpu_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            last_grant <= 1'b1;
            acc_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
            cpu_done   <= 1'b0;
            ext_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req | ext_req) begin
                        mem_en     <= 1'b1;
                        mem_we     <= win_we;
                        acc_we     <= win_we;
                        mem_addr   <= pick_ext ? ext_addr : cpu_addr;
                        mem_wdata  <= pick_ext ? ext_wdata : cpu_wdata;
                        lat_cnt    <= CW'(1);
                        last_grant <= pick_ext;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (lat_cnt == CW'(MEM_LAT)) begin
                        mem_en <= 1'b0;
                        state  <= DONE;
                        if (last_grant) begin
                            ext_done <= 1'b1;
                            if (!acc_we) ext_rdata <= mem_rdata;
                        end else begin
                            cpu_done <= 1'b1;
                            if (!acc_we) cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                DONE: begin
                    cpu_done <= 1'b0;
                    ext_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a cycle-count reference model.
module tb_mem_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done, cpu_stall;
    logic              ext_req = 1'b0, ext_we = 1'b0;
    logic [ADDR_W-1:0] ext_addr = '0;
    logic [DATA_W-1:0] ext_wdata = '0;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_done;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] ram  [256];
    logic [DATA_W-1:0] mram [256];
    int n_checks = 0, n_fail = 0, cyc = 0;

    // reference model: an access granted at edge g completes at g+MEM_LAT, next grant no earlier than g+MEM_LAT+2
    bit                act = 0, own = 1, last_own = 1, a_we = 0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    int                done_at = 0, free_at = 0;
    bit                e_en = 0, e_we = 0, e_cdone = 0, e_edone = 0;
    logic [DATA_W-1:0] e_crd = '0, e_erd = '0;

    always #5 clk = ~clk;
    assign mem_rdata = ram[mem_addr[7:0]];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_done(ext_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic model_reset();
        act = 0; last_own = 1; a_we = 0; a_addr = '0; a_wdata = '0; free_at = 0;
        e_en = 0; e_we = 0; e_cdone = 0; e_edone = 0; e_crd = '0; e_erd = '0;
    endtask

    task automatic tick();
        if (mem_en && mem_we) ram[mem_addr[7:0]] = mem_wdata;
        @(posedge clk);
        cyc++;
        e_we = 0; e_cdone = 0; e_edone = 0;
        if (reset_n) begin
            if (act && cyc == done_at) begin
                act = 0;
                if (own) e_edone = 1; else e_cdone = 1;
                if (!a_we && own) e_erd = mram[a_addr[7:0]];
                if (!a_we && !own) e_crd = mram[a_addr[7:0]];
            end else if (!act && cyc >= free_at && (cpu_req || ext_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                own = (cpu_req && ext_req) ? !last_own : ext_req;
`else
                own = ext_req;
`endif
                last_own = own; act = 1;
                done_at = cyc + MEM_LAT; free_at = cyc + MEM_LAT + 2;
                a_we = own ? ext_we : cpu_we;
                a_addr = own ? ext_addr : cpu_addr;
                a_wdata = own ? ext_wdata : cpu_wdata;
                e_we = a_we;
                if (a_we) mram[a_addr[7:0]] = a_wdata;
            end
        end
        e_en = act;
        @(negedge clk);
    endtask

    task automatic assert_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic preload(input int a, input logic [DATA_W-1:0] d);
        ram[a] = d; mram[a] = d;
    endtask

    task automatic run_access(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, output int lat, output int we_cyc);
        if (port) begin ext_we = we; ext_addr = addr; ext_wdata = wdata; ext_req = 1'b1; end
        else begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
        lat = -1; we_cyc = 0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            tick();
            if (mem_we === 1'b1) we_cyc++;
            if ((port ? ext_done : cpu_done) === 1'b1) lat = i;
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        assert_reset();
        n_checks++;
        if ({mem_en, mem_we, cpu_done, ext_done, cpu_stall} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, cpu_done, ext_done, cpu_stall});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (cpu_rdata !== '0 || ext_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", cpu_rdata, ext_rdata);
        end
        release_reset();
    endtask

    task automatic test_single_read();
        preload(8'h10, 16'hBEEF);
        cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h5555; cpu_req = 1'b1;
        #1;
        n_checks++;
        if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL sr_stall_pre: got %b want 1", cpu_stall); end
        for (int i = 0; i <= MEM_LAT; i++) begin
            tick();
            n_checks++;
            if (mem_en !== (i < MEM_LAT)) begin n_fail++; $display("FAIL sr_mem_en[%0d]: got %b want %b", i, mem_en, i < MEM_LAT); end
            n_checks++;
            if (cpu_done !== (i == MEM_LAT)) begin n_fail++; $display("FAIL sr_done[%0d]: got %b want %b", i, cpu_done, i == MEM_LAT); end
            n_checks++;
            if (cpu_stall !== (i < MEM_LAT)) begin n_fail++; $display("FAIL sr_stall[%0d]: got %b want %b", i, cpu_stall, i < MEM_LAT); end
        end
        n_checks++;
        if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL sr_rdata: got %h want beef", cpu_rdata); end
        n_checks++;
        if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL sr_addr: got %h want 0010", mem_addr); end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if (cpu_done !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL sr_after: got done %b en %b want 0 0", cpu_done, mem_en); end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] prev;
        int lat, wc;
        prev = ext_rdata;
        run_access(1'b1, 1'b1, 16'h0003, 16'h1234, lat, wc);
        n_checks++;
        if (lat != MEM_LAT) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, MEM_LAT); end
        n_checks++;
        if (wc != 1) begin n_fail++; $display("FAIL wr_we_cycles: got %0d want 1", wc); end
        n_checks++;
        if (ext_rdata !== prev) begin n_fail++; $display("FAIL wr_ext_rdata: got %h want %h", ext_rdata, prev); end
        run_access(1'b0, 1'b0, 16'h0003, 16'h0000, lat, wc);
        n_checks++;
        if (lat != MEM_LAT || wc != 0) begin n_fail++; $display("FAIL rd_timing: got lat %0d we %0d want %0d 0", lat, wc, MEM_LAT); end
        n_checks++;
        if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_after_wr: got %h want 1234", cpu_rdata); end
        n_checks++;
        if (ext_rdata !== prev) begin n_fail++; $display("FAIL rd_ext_hold: got %h want %h", ext_rdata, prev); end
    endtask

    task automatic test_cpu_waits();
        int n;
        preload(5, 16'hA5A5); preload(6, 16'h6666);
        ext_we = 1'b0; ext_addr = 16'h0005; ext_req = 1'b1;
        tick();
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0005) begin n_fail++; $display("FAIL cw_ext_grant: got en %b addr %h want 1 0005", mem_en, mem_addr); end
        cpu_we = 1'b0; cpu_addr = 16'h0006; cpu_req = 1'b1;
        n = -1;
        for (int i = 1; i < 20 && n < 0; i++) begin
            tick();
            if (ext_done === 1'b1) n = i;
        end
        n_checks++;
        if (n != MEM_LAT || cpu_done !== 1'b0) begin n_fail++; $display("FAIL cw_ext_done: got %0d cpu_done %b want %0d 0", n, cpu_done, MEM_LAT); end
        n_checks++;
        if (ext_rdata !== 16'hA5A5 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL cw_ext_data: got %h stall %b want a5a5 1", ext_rdata, cpu_stall); end
        ext_req = 1'b0;
        tick();
        n_checks++;
        if (mem_en !== 1'b0) begin n_fail++; $display("FAIL cw_idle_gap: got en %b want 0", mem_en); end
        tick();
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0006) begin n_fail++; $display("FAIL cw_cpu_grant: got en %b addr %h want 1 0006", mem_en, mem_addr); end
        n = -1;
        for (int i = 1; i < 20 && n < 0; i++) begin
            tick();
            if (cpu_done === 1'b1) n = i;
        end
        n_checks++;
        if (n != MEM_LAT || cpu_rdata !== 16'h6666) begin n_fail++; $display("FAIL cw_cpu_done: got %0d %h want %0d 6666", n, cpu_rdata, MEM_LAT); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        int prev_t, t;
        bit exp_ext;
        assert_reset();
        release_reset();
        preload(1, 16'h1111); preload(2, 16'h2222);
        cpu_we = 1'b0; cpu_addr = 16'h0001; ext_we = 1'b0; ext_addr = 16'h0002;
        cpu_req = 1'b1; ext_req = 1'b1;
        prev_t = -1;
        for (int k = 0; k < 4; k++) begin
            t = -1;
            for (int i = 0; i < 20 && t < 0; i++) begin
                tick();
                if (cpu_done === 1'b1 || ext_done === 1'b1) t = cyc;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_ext = (k % 2) == 1;
`else
            exp_ext = 1'b1;
`endif
            n_checks++;
            if (t < 0 || ext_done !== exp_ext || cpu_done !== !exp_ext) begin
                n_fail++; $display("FAIL tie_winner[%0d]: got cpu %b ext %b want ext=%b", k, cpu_done, ext_done, exp_ext);
            end
            if (k > 0) begin
                n_checks++;
                if (t - prev_t != MEM_LAT + 2) begin n_fail++; $display("FAIL tie_period[%0d]: got %0d want %0d", k, t - prev_t, MEM_LAT + 2); end
            end
            prev_t = t;
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int dn, lat, wc;
        cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hDEAD; cpu_req = 1'b1;
        tick();
        n_checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got en %b we %b want 1 1", mem_en, mem_we); end
        assert_reset();
        cpu_req = 1'b0;
        n_checks++;
        if ({mem_en, mem_we, cpu_done, ext_done} !== 4'b0) begin n_fail++; $display("FAIL rm_async_clear: got %b want 0000", {mem_en, mem_we, cpu_done, ext_done}); end
        release_reset();
        dn = 0;
        for (int i = 0; i < MEM_LAT + 3; i++) begin
            tick();
            if (cpu_done === 1'b1 || ext_done === 1'b1) dn++;
        end
        n_checks++;
        if (dn != 0) begin n_fail++; $display("FAIL rm_no_done: got %0d want 0", dn); end
        run_access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, wc);
        n_checks++;
        if (lat != MEM_LAT || cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rm_recover: got lat %0d data %h want %0d beef", lat, cpu_rdata, MEM_LAT); end
        cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
        for (int i = 0; i < 20 && cpu_done !== 1'b1; i++) tick();
        assert_reset();
        cpu_req = 1'b0;
        n_checks++;
        if (cpu_done !== 1'b0 || cpu_rdata !== '0) begin n_fail++; $display("FAIL rm_done_drop: got done %b data %h want 0 0", cpu_done, cpu_rdata); end
        release_reset();
    endtask

    task automatic test_req_drop();
        int n;
        cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        n = -1;
        for (int i = 1; i < 20 && n < 0; i++) begin
            tick();
            if (cpu_done === 1'b1) n = i;
        end
        n_checks++;
        if (n != MEM_LAT) begin n_fail++; $display("FAIL drop_still_done: got %0d want %0d", n, MEM_LAT); end
        tick();
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        for (int c = 0; c < 600; c++) begin
            if (cpu_req && e_cdone) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 16'($urandom_range(0, 7)); cpu_wdata = 16'($urandom);
            end
            if (ext_req && e_edone) ext_req = 1'b0;
            else if (!ext_req && $urandom_range(0, 2) == 0) begin
                ext_req = 1'b1; ext_we = 1'($urandom_range(0, 1));
                ext_addr = 16'($urandom_range(0, 7)); ext_wdata = 16'($urandom);
            end
            tick();
            n_checks++;
            if ({mem_en, mem_we, cpu_done, ext_done} !== {e_en, e_we, e_cdone, e_edone}) begin
                n_fail++; $display("FAIL rnd_ctrl @%0d: got %b want %b", cyc, {mem_en, mem_we, cpu_done, ext_done}, {e_en, e_we, e_cdone, e_edone});
            end
            n_checks++;
            if (mem_addr !== a_addr || mem_wdata !== a_wdata) begin
                n_fail++; $display("FAIL rnd_bus @%0d: got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, a_addr, a_wdata);
            end
            n_checks++;
            if (cpu_rdata !== e_crd || ext_rdata !== e_erd) begin
                n_fail++; $display("FAIL rnd_rdata @%0d: got %h/%h want %h/%h", cyc, cpu_rdata, ext_rdata, e_crd, e_erd);
            end
            n_checks++;
            if (cpu_stall !== (cpu_req & ~e_cdone)) begin
                n_fail++; $display("FAIL rnd_stall @%0d: got %b want %b", cyc, cpu_stall, cpu_req & ~e_cdone);
            end
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin ram[i] = '0; mram[i] = '0; end
        @(negedge clk);
        test_reset();
        test_single_read();
        test_write_read();
        test_cpu_waits();
        test_tie();
        test_reset_mid();
        test_req_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
